// File: rtl/tx_buffer_write_arbiter.sv
// tx_buffer_write_arbiter: round-robin whole-frame arbiter for the TX frame buffer write port
module tx_buffer_write_arbiter #(
    parameter int ADDR_W = 9,
    parameter int MAX_FRAME_QW = 190
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W:0]   len0,
    output logic              gnt0,
    input  logic              wr_valid0,
    input  logic [63:0]       wr_data0,
    input  logic              req1,
    input  logic [ADDR_W:0]   len1,
    output logic              gnt1,
    input  logic              wr_valid1,
    input  logic [63:0]       wr_data1,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [ADDR_W:0]   commited_wr_addr,
    input  logic [ADDR_W:0]   commited_rd_addr,
    output logic              len_err
);
    typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_t;
    localparam logic [ADDR_W:0] one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] depth = one << ADDR_W;
    localparam logic [ADDR_W:0] max_len = (ADDR_W+1)'(MAX_FRAME_QW);
    state_t state, state_n;
    logic [ADDR_W:0] wr_ptr, count, used, free;
    logic last_served, req0_d, req1_d;
    logic legal0, legal1, elig0, elig1, grant, pick, accept, last;

    // free space, eligibility, grant choice and next state from registered values
    always_comb begin
        used = wr_ptr - commited_rd_addr;
        free = depth - used;
        legal0 = len0 != '0 && len0 <= max_len;
        legal1 = len1 != '0 && len1 <= max_len;
        elig0 = req0 && legal0 && len0 <= free;
        elig1 = req1 && legal1 && len1 <= free;
        grant = state == IDLE && (elig0 || elig1);
        pick = (elig0 && elig1) ? !last_served : elig1;
        accept = state == XFER && (last_served ? wr_valid1 : wr_valid0);
        last = accept && count == one;
        state_n = (state == IDLE && grant) ? XFER :
                  last ? COMMIT :
                  (state == COMMIT) ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // grant ownership, write streaming, pointer publication and length-error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            commited_wr_addr <= '0;
            len_err <= 1'b0;
            wr_ptr <= '0;
            count <= '0;
            last_served <= 1'b0;
            req0_d <= 1'b0;
            req1_d <= 1'b0;
        end else begin
            req0_d <= req0;
            req1_d <= req1;
            len_err <= (req0 && !req0_d && !legal0) || (req1 && !req1_d && !legal1);
            mem_wr_en <= accept;
            if (grant) begin
                last_served <= pick;
                count <= pick ? len1 : len0;
                gnt0 <= !pick;
                gnt1 <= pick;
            end
            if (accept) begin
                mem_wr_addr <= wr_ptr[ADDR_W-1:0];
                mem_wr_data <= last_served ? wr_data1 : wr_data0;
                wr_ptr <= wr_ptr + one;
                count <= count - one;
            end
            if (last) begin
                gnt0 <= 1'b0;
                gnt1 <= 1'b0;
            end
            if (state == COMMIT) commited_wr_addr <= wr_ptr;
        end
    end
endmodule

// File: doc/tx_buffer_write_arbiter.md
Name: tx_buffer_write_arbiter

Overview:
- Shares the write port of the 512-qword TX frame buffer between two frame producers, e.g. two DMA engines.
- Grants whole frames, round-robin, only when the frame fits in the buffer's free space.
- Streams granted qwords into the buffer and publishes commited_wr_addr to the TX MAC reader after each complete frame.
- Sits between the producers and the buffer/TX MAC interface; consumes that interface's commited_rd_addr.

Parameters:
ADDR_W, 9, buffer address width in qwords; buffer depth is 2^ADDR_W.
MAX_FRAME_QW, 190, largest legal frame length in qwords, header qword included; must not exceed 2^ADDR_W.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req0  in  1  producer 0 has a frame ready
len0  in  ADDR_W+1  producer 0 frame length in qwords
gnt0  out  1  producer 0 owns the write port
wr_valid0  in  1  producer 0 qword valid
wr_data0  in  64  producer 0 qword
req1, len1, gnt1, wr_valid1, wr_data1  as for producer 0
mem_wr_en  out  1  buffer write enable
mem_wr_addr  out  ADDR_W  buffer write address
mem_wr_data  out  64  buffer write data
commited_wr_addr  out  ADDR_W+1  published write pointer
commited_rd_addr  in  ADDR_W+1  reader's published read pointer
len_err  out  1  one-cycle pulse: requested length is illegal

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; wr_ptr, count and last_served = 0; state IDLE.
- Pointers: wr_ptr and commited_* are ADDR_W+1 bits, modulo 2^(ADDR_W+1).
- mem_wr_addr = wr_ptr[ADDR_W-1:0]. This gives natural wrap from 511 to 0.
- used = wr_ptr - commited_rd_addr, modulo 2^(ADDR_W+1).
- free = 2^ADDR_W - used, computed combinationally from registered values.
- Legal length: 1 <= lenN <= MAX_FRAME_QW.
- Eligible(N): reqN AND lenN legal AND lenN <= free.
- States: IDLE, XFER, COMMIT.
- IDLE:
  - One producer eligible: grant it.
  - Both eligible: grant the one not equal to last_served.
  - On grant: next cycle gntN=1, count<=lenN, last_served<=N, state XFER.
  - reqN with illegal lenN: len_err pulses 1 cycle, once per rising edge of reqN; that request is never granted.
  - A legal request larger than free waits with no error.
- XFER:
  - Each cycle with wr_validN=1 for the granted N:
    - next cycle mem_wr_en=1, mem_wr_addr=old wr_ptr[ADDR_W-1:0], mem_wr_data=wr_dataN (1-cycle registered latency);
    - wr_ptr+=1, count-=1.
  - Bubbles (wr_validN=0) allowed; no timeout.
  - wr_valid of the ungranted producer is ignored.
  - When the qword with count==1 is accepted: gntN drops the next cycle and state goes to COMMIT.
  - Qwords offered after the last one are ignored (gnt already low).
- COMMIT:
  - commited_wr_addr <= wr_ptr, one cycle after the final mem_wr_en, so the data is in the buffer before it is published.
  - Then state IDLE.
  - Minimum one idle cycle between consecutive grants.
- Requests:
  - reqN and lenN must be held stable until gntN.
  - Producer deasserts reqN the cycle after gntN rises.
  - A request withdrawn before grant is simply not served.
- Producer contract: first qword is the frame header with byte count in [63:32]; lenN = ceil(bytes/8)+1. Not checked here.
- commited_rd_addr moves only forward, so free is conservative. A mid-frame reader advance is harmless.
- Full buffer (used == 2^ADDR_W): no grant until the reader frees space.
- Exact fit (len == free) is granted.
- Reset mid-XFER: the partial frame is discarded. commited_wr_addr returns to 0.
- The reader must be reset together with this block.

Test Plan:
- Reset, commited_rd_addr=0; req0=1, len0=8, 8 back-to-back valids.
  -> gnt0 high 8 cycles; mem_wr_addr 0..7.
  -> commited_wr_addr=8 one cycle after the last write; gnt0 low.
- req0 and req1 held, len=4 each, from reset.
  -> grants alternate 1,0,1,0 (last_served=0 at reset).
  -> commited_wr_addr steps 4, 8, 12, 16.
- wr_ptr=508, len0=8, commited_rd_addr=508.
  -> mem_wr_addr 508,509,510,511,0,1,2,3.
  -> commited_wr_addr=516 (10-bit).
- used=510 (free=2), len0=3 -> no grant.
  -> raise commited_rd_addr by 1 -> grant next cycle.
  -> len0=2 with free=2 -> granted immediately.
- len0=0, then len0=MAX_FRAME_QW+1.
  -> one len_err pulse each; no gnt0.
  -> a simultaneous legal req1 is served normally.
- Assert reset after 3 of 8 qwords.
  -> gnt0=0, mem_wr_en=0, commited_wr_addr=0 asynchronously.
  -> a fresh len0=2 writes addresses 0,1.
